// File: rtl/div_unit.sv
// Iterative 32-bit integer divider for the EX stage (DIV / DIVU).
// One restoring shift-subtract step per cycle on operand magnitudes, with sign
// correction folded into the final step. Holds the pipeline via stall_request
// while a division is in flight and pulses done for one cycle when hi/lo are fresh.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           EX stage holds a divide; request a division
//   is_signed       1 = DIV (two's complement), 0 = DIVU
//   flush           abandon any in-flight division
//   operand_a/b     dividend / divisor, latched on acceptance
//   stall_request   pipeline hold request (combinational)
//   done            one-cycle completion pulse
//   hi / lo         remainder / quotient, held until the next completion
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic             flush,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             stall_request,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   count_q;
  logic [WIDTH-1:0]  rem_q;
  logic [WIDTH-1:0]  quo_q;
  logic [WIDTH-1:0]  divisor_q;
  logic              neg_quo_q;
  logic              neg_rem_q;

  logic              accept;
  logic              a_neg;
  logic              b_neg;
  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;
  logic [WIDTH:0]    rem_shift;
  logic [WIDTH:0]    diff;
  logic              take;
  logic [WIDTH-1:0]  rem_next;
  logic [WIDTH-1:0]  quo_next;
  logic [WIDTH-1:0]  hi_fix;
  logic [WIDTH-1:0]  lo_fix;
  logic              last_step;

  always_comb begin
    accept    = (state_q == StIdle) && start && !flush;
    a_neg     = is_signed && operand_a[WIDTH-1];
    b_neg     = is_signed && operand_b[WIDTH-1];
    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude.
    a_mag     = a_neg ? (~operand_a + 1'b1) : operand_a;
    b_mag     = b_neg ? (~operand_b + 1'b1) : operand_b;

    // Bring the next dividend bit into the partial remainder and try a subtract;
    // no borrow out of the extra top bit means the divisor fits.
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, divisor_q};
    take      = !diff[WIDTH];
    rem_next  = take ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_next  = {quo_q[WIDTH-2:0], take};

    hi_fix    = neg_rem_q ? (~rem_next + 1'b1) : rem_next;
    lo_fix    = neg_quo_q ? (~quo_next + 1'b1) : quo_next;
    last_step = (count_q == CntW'(WIDTH - 1));

    stall_request = accept || ((state_q == StBusy) && !flush);
    done          = (state_q == StDone) && !flush;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else if (flush) begin
      // Partial result is discarded; hi/lo keep the last completed values.
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= a_mag;
            divisor_q <= b_mag;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            if (operand_b == '0) begin
              hi      <= operand_a;
              lo      <= '1;
              state_q <= StDone;
            end else begin
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          rem_q   <= rem_next;
          quo_q   <= quo_next;
          count_q <= count_q + 1'b1;
          if (last_step) begin
            hi      <= hi_fix;
            lo      <= lo_fix;
            state_q <= StDone;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: a cycle-indexed behavioural model (completion
// cycle plus arithmetic results) checked every cycle, plus directed literal cases.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic        flush;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        stall_request;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .is_signed    (is_signed),
    .flush        (flush),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .stall_request(stall_request),
    .done         (done),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result straight from the arithmetic definition.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] r_hi, output logic [31:0] r_lo);
    longint sa, sb, q, r;
    if (b == 32'h0) begin
      r_hi = a;
      r_lo = 32'hFFFF_FFFF;
    end else if (!s) begin
      r_lo = a / b;
      r_hi = a % b;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      r_lo = q[31:0];
      r_hi = r[31:0];
    end
  endtask

  // Model: a division accepted in cycle n completes (done) in cycle done_at;
  // hi/lo change at the end of cycle done_at-1.
  bit          model_ok = 1'b0;
  bit          inflight = 1'b0;
  longint      n = 0;
  longint      done_at = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;

  always @(negedge clk) begin
    logic e_stall;
    logic e_done;
    if (model_ok) begin
      chk("hi", hi, exp_hi);
      chk("lo", lo, exp_lo);
      if (!rst) begin
        e_stall = !flush && ((!inflight && start) || (inflight && n < done_at));
        e_done  = !flush && inflight && (n == done_at);
        chk("stall_request", {31'b0, stall_request}, {31'b0, e_stall});
        chk("done", {31'b0, done}, {31'b0, e_done});
      end
    end
    if (rst) begin
      inflight = 1'b0;
      exp_hi   = '0;
      exp_lo   = '0;
      model_ok = 1'b1;
    end else if (flush) begin
      inflight = 1'b0;
    end else if (inflight) begin
      if (n == done_at - 1) begin
        exp_hi = pend_hi;
        exp_lo = pend_lo;
      end
      if (n == done_at) inflight = 1'b0;
    end else if (start) begin
      ref_div(operand_a, operand_b, is_signed, pend_hi, pend_lo);
      inflight = 1'b1;
      done_at  = n + ((operand_b == 32'h0) ? 1 : 33);
      if (operand_b == 32'h0) begin
        exp_hi = pend_hi;
        exp_lo = pend_lo;
      end
    end
    n++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one division and check completion latency and literal results.
  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int exp_lat,
                         input logic [31:0] e_lo, input logic [31:0] e_hi);
    int lat = -1;
    start = 1'b1; operand_a = a; operand_b = b; is_signed = s;
    step();
    // Scramble inputs to show operands were latched.
    start = 1'b0; operand_a = $urandom; operand_b = $urandom; is_signed = ~s;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: no done within 40 cycles", name);
    end else begin
      chk({name, " latency"}, lat, exp_lat);
      chk({name, " lo"}, lo, e_lo);
      chk({name, " hi"}, hi, e_hi);
    end
    step();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int done_cnt;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; flush = 1'b0;
    operand_a = '0; operand_b = '0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset stall", {31'b0, stall_request}, 32'h0);
    chk("reset done", {31'b0, done}, 32'h0);
    chk("reset hi", hi, 32'h0);
    chk("reset lo", lo, 32'h0);
    step();

    run_div("divu 100/7", 32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2);
    run_div("div -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("div min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 32'h8000_0000, 32'h0);
    run_div("divu 5/0", 32'd5, 32'd0, 1'b0, 1, 32'hFFFF_FFFF, 32'd5);

    // Flush at T+10, restart at T+12.
    start = 1'b1; operand_a = 32'd100; operand_b = 32'd7; is_signed = 1'b0;
    step();
    start = 1'b0;
    repeat (9) step();
    flush = 1'b1;
    @(negedge clk);
    chk("flush stall", {31'b0, stall_request}, 32'h0);
    chk("flush done", {31'b0, done}, 32'h0);
    step();
    flush = 1'b0;
    step();
    @(negedge clk);
    chk("flush kept lo", lo, 32'hFFFF_FFFF);
    chk("flush kept hi", hi, 32'd5);
    run_div("divu after flush", 32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2);

    // Reset at T+5 aborts with no done.
    start = 1'b1; operand_a = 32'd100; operand_b = 32'd7; is_signed = 1'b0;
    step();
    start = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst stall", {31'b0, stall_request}, 32'h0);
    chk("rst hi", hi, 32'h0);
    chk("rst lo", lo, 32'h0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    chk("rst no done", done_cnt, 0);
    step();

    // Random traffic, including starts during BUSY/DONE, flushes and resets.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      flush     = ($urandom_range(0, 39) == 0);
      start     = ($urandom_range(0, 2) == 0);
      is_signed = 1'($urandom_range(0, 1));
      operand_a = pick();
      operand_b = pick();
      step();
    end
    rst = 1'b0; flush = 1'b0; start = 1'b0;
    repeat (40) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
